// File: rtl/qq_enq_feeder_pkg.sv
// qq_pkg: shared types and constants for the quickQueue ingress feeder.
//
// Contents:
//   QQ_DATA_W      width of each half of a queue entry
//   QQ_OCC_W       width of the queue occupancy / array_size fields
//   qq_entry_t     packed {lt, rt} entry as buffered by the skid FIFO
//   feeder_state_t informational feeder FSM state
package qq_pkg;

   localparam int QQ_DATA_W = 32;
   localparam int QQ_OCC_W  = 8;

   typedef struct packed {
      logic [QQ_DATA_W-1:0] lt;
      logic [QQ_DATA_W-1:0] rt;
   } qq_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/qq_enq_feeder_if.sv
// qq_enq_feeder_if: producer-side valid/ready stream carrying one entry pair.
//
// Signals:
//   s_valid    producer has an entry
//   s_ready    feeder can accept an entry this cycle
//   s_data_lt  left word of the entry
//   s_data_rt  right word of the entry
//
// Modports:
//   master  producer side (drives valid and data)
//   slave   feeder side (drives ready)
interface qq_enq_feeder_if #(
   parameter int DATA_W = 32
);

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data_lt;
   logic [DATA_W-1:0] s_data_rt;

   modport master (
      output s_valid,
      output s_data_lt,
      output s_data_rt,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data_lt,
      input  s_data_rt,
      output s_ready
   );

endinterface

// File: rtl/qq_enq_feeder_skid_fifo.sv
// qq_skid_fifo: small synchronous FIFO of qq_entry_t used as the feeder's
// skid buffer.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push       write wr_data this edge (ignored when full)
//   wr_data    entry to write
//   pop        discard the head entry this edge (ignored when empty)
//   rd_data    current head entry (valid when !empty)
//   count      number of entries held, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module qq_skid_fifo
   import qq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  qq_entry_t        wr_data,
   input  logic             pop,
   output qq_entry_t        rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   qq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset: an entry is only ever read after the count
   // says it was written, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the separate
   // count is what tells a full FIFO apart from an empty one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/qq_enq_feeder.sv
// qq_enq_feeder: ingress stage directly upstream of quickQueueTop.
//
// Accepts entry pairs over a valid/ready stream, buffers them in a skid
// FIFO and issues single-cycle enq pulses with registered data into the
// queue. The queue has no full flag, so this block keeps its own count of
// resident entries (its enq pulses minus the queue's deq pulses) and only
// issues while that count is below array_size.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   prod         producer stream (qq_enq_feeder_if.slave)
//   array_size   queue capacity currently configured
//   deq_i        copy of the deq strobe driven into the queue
//   enq          enqueue strobe to the queue
//   data_lt_o    left word to the queue
//   data_rt_o    right word to the queue
//   occupancy    entries believed resident in the queue
//   q_full       occupancy >= array_size
//   q_empty      occupancy == 0
//
// Optional feature (macro QQ_FEEDER_STATS_EN):
//   stall_cycles saturating count of cycles spent in STALL
//   drop_deq     saturating count of deq_i pulses ignored at occupancy 0
module qq_enq_feeder
   import qq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = QQ_DATA_W,
   parameter int OCC_W      = QQ_OCC_W
) (
   input  logic               clk,
   input  logic               rst,
   qq_enq_feeder_if.slave     prod,
   input  logic [OCC_W-1:0]   array_size,
   input  logic               deq_i,
   output logic               enq,
   output logic [DATA_W-1:0]  data_lt_o,
   output logic [DATA_W-1:0]  data_rt_o,
   output logic [OCC_W-1:0]   occupancy,
   output logic               q_full,
   output logic               q_empty
`ifdef QQ_FEEDER_STATS_EN
   ,
   output logic [15:0]        stall_cycles,
   output logic [15:0]        drop_deq
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   qq_entry_t        wr_entry;
   qq_entry_t        head;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_next;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             issue;
   logic             deq_eff;
   logic [OCC_W-1:0] occ_next;
   feeder_state_t    state;
   feeder_state_t    state_next;

   assign wr_entry.lt = prod.s_data_lt;
   assign wr_entry.rt = prod.s_data_rt;

   // Ready depends only on the registered FIFO count, never on this cycle's
   // pop, so there is no combinational path from the queue side to s_ready.
   assign prod.s_ready = !fifo_full;
   assign push         = prod.s_valid && prod.s_ready;

   // The issue rule uses registered occupancy only: a credit returned by
   // deq_i becomes usable one edge later.
   assign issue   = !fifo_empty && (occupancy < array_size);
   assign deq_eff = deq_i && (occupancy != '0);

   assign q_full  = (occupancy >= array_size);
   assign q_empty = (occupancy == '0);

   qq_skid_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (issue),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Occupancy bookkeeping: an issue and an accepted deq in the same cycle
   // cancel out; a deq seen while empty is ignored rather than underflowing.
   always_comb begin
      occ_next = occupancy;
      if (issue && !deq_eff) begin
         occ_next = occupancy + OCC_W'(1);
      end else if (!issue && deq_eff) begin
         occ_next = occupancy - OCC_W'(1);
      end
   end

   // Queue-side outputs: enq is a one-cycle strobe, data holds its last
   // value between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enq       <= 1'b0;
         data_lt_o <= '0;
         data_rt_o <= '0;
         occupancy <= '0;
      end else begin
         enq       <= issue;
         occupancy <= occ_next;
         if (issue) begin
            data_lt_o <= head.lt;
            data_rt_o <= head.rt;
         end
      end
   end

   // The FSM is a status view of the post-update FIFO count and occupancy;
   // the issue rule above does not depend on it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = IDLE;
      count_next = fifo_count + CNT_W'(push) - CNT_W'(issue);
      if (count_next == '0) begin
         state_next = IDLE;
      end else if (occ_next < array_size) begin
         state_next = ISSUE;
      end else begin
         state_next = STALL;
      end
   end

`ifdef QQ_FEEDER_STATS_EN
   // Saturating statistics counters for stalls and ignored deq pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         drop_deq     <= '0;
      end else begin
         if ((state == STALL) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         if (deq_i && (occupancy == '0) && (drop_deq != 16'hFFFF)) begin
            drop_deq <= drop_deq + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_qq_enq_feeder.sv
// tb_qq_enq_feeder: self-checking bench for qq_enq_feeder.
//
// Every accepted producer entry is pushed to a scoreboard queue; every enq
// pulse pops the oldest entry and compares the data. Occupancy, flags and
// FIFO state are checked against hand-derived values at each milestone.
module tb_qq_enq_feeder;
   import qq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  array_size;
   logic        deq_i;
   logic        enq;
   logic [31:0] data_lt_o;
   logic [31:0] data_rt_o;
   logic [7:0]  occupancy;
   logic        q_full;
   logic        q_empty;
`ifdef QQ_FEEDER_STATS_EN
   logic [15:0] stall_cycles;
   logic [15:0] drop_deq;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int enq_count    = 0;
   int accepted     = 0;
   qq_entry_t sb [$];

   qq_enq_feeder_if #(.DATA_W(32)) prod_if ();

   always #5 clk = ~clk;

   qq_enq_feeder #(
      .FIFO_DEPTH   (4),
      .DATA_W       (32),
      .OCC_W        (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .prod         (prod_if.slave),
      .array_size   (array_size),
      .deq_i        (deq_i),
      .enq          (enq),
      .data_lt_o    (data_lt_o),
      .data_rt_o    (data_rt_o),
      .occupancy    (occupancy),
      .q_full       (q_full),
      .q_empty      (q_empty)
`ifdef QQ_FEEDER_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .drop_deq     (drop_deq)
`endif
   );

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // One clock: record an accepted push before the edge, then sample the
   // queue side 1 time unit after the edge and score any enq pulse.
   task automatic tick();
      qq_entry_t e;
      bit        pushed;
      pushed = !rst && prod_if.s_valid && prod_if.s_ready;
      if (pushed) begin
         e.lt = prod_if.s_data_lt;
         e.rt = prod_if.s_data_rt;
         sb.push_back(e);
         accepted++;
      end
      @(posedge clk);
      #1;
      if (enq === 1'b1) begin
         enq_count++;
         if (sb.size() == 0) begin
            checkOutput("enq_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("enq_data_lt", data_lt_o, e.lt);
            checkOutput("enq_data_rt", data_rt_o, e.rt);
         end
      end
   endtask

   task automatic applyStimulus(input bit valid, input logic [31:0] lt,
                                input logic [31:0] rt, input bit deq);
      prod_if.s_valid   = valid;
      prod_if.s_data_lt = lt;
      prod_if.s_data_rt = rt;
      deq_i             = deq;
      tick();
   endtask

   initial begin
      int base;
      rst               = 1'b1;
      array_size        = 8'd0;
      deq_i             = 1'b0;
      prod_if.s_valid   = 1'b0;
      prod_if.s_data_lt = '0;
      prod_if.s_data_rt = '0;
      #2;
      checkOutput("rst_q_full_size0", 32'(q_full), 32'd1);
      array_size = 8'd3;
      #1;
      checkOutput("rst_q_full_size3", 32'(q_full), 32'd0);
      checkOutput("rst_q_empty", 32'(q_empty), 32'd1);
      checkOutput("rst_enq", 32'(enq), 32'd0);
      checkOutput("rst_data_lt", data_lt_o, 32'd0);
      checkOutput("rst_data_rt", data_rt_o, 32'd0);
      checkOutput("rst_occ", 32'(occupancy), 32'd0);
      checkOutput("rst_s_ready", 32'(prod_if.s_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // deq_i at occupancy 0 must be ignored.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
         checkOutput("idle_deq_enq", 32'(enq), 32'd0);
         checkOutput("idle_deq_occ", 32'(occupancy), 32'd0);
         checkOutput("idle_deq_empty", 32'(q_empty), 32'd1);
      end
`ifdef QQ_FEEDER_STATS_EN
      checkOutput("stats_drop_deq", 32'(drop_deq), 32'd5);
`endif

      // Five pushes against a capacity of three.
      enq_count = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h49283049 + 32'(i), 32'(i), 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      end
      checkOutput("fill_enq_count", 32'(enq_count), 32'd3);
      checkOutput("fill_occ", 32'(occupancy), 32'd3);
      checkOutput("fill_q_full", 32'(q_full), 32'd1);
      checkOutput("fill_state", 32'(dut.state), 32'(STALL));
      checkOutput("fill_fifo_count", 32'(dut.fifo_count), 32'd2);

      // One credit returned, then one issue of the next entry.
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("credit_occ", 32'(occupancy), 32'd2);
      checkOutput("credit_enq", 32'(enq), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      checkOutput("credit_enq_next", 32'(enq), 32'd1);
      checkOutput("credit_lt", data_lt_o, 32'h4928304C);
      checkOutput("credit_occ_back", 32'(occupancy), 32'd3);

      // Issue and deq on the same edge at occupancy 2.
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("same_pre_occ", 32'(occupancy), 32'd2);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("same_enq", 32'(enq), 32'd1);
      checkOutput("same_occ", 32'(occupancy), 32'd2);
      checkOutput("same_state_idle", 32'(dut.state), 32'(IDLE));

      // array_size 0: FIFO fills to depth, then ready drops, no issue.
      array_size = 8'd0;
      base       = enq_count;
      accepted   = 0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 32'h4928304E + 32'(i), 32'd10 + 32'(i), 1'b0);
      end
      checkOutput("zero_accepted", 32'(accepted), 32'd4);
      checkOutput("zero_s_ready", 32'(prod_if.s_ready), 32'd0);
      checkOutput("zero_no_enq", 32'(enq_count - base), 32'd0);
      checkOutput("zero_q_full", 32'(q_full), 32'd1);
      checkOutput("zero_fifo_count", 32'(dut.fifo_count), 32'd4);

      // Capacity restored: one issue fills the remaining credit.
      prod_if.s_valid = 1'b0;
      array_size      = 8'd3;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      checkOutput("resume_lt", data_lt_o, 32'h4928304E);
      checkOutput("resume_occ", 32'(occupancy), 32'd3);

      // Capacity lowered below occupancy: no issue until drained below it.
      array_size = 8'd1;
      base       = enq_count;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("lower_no_enq", 32'(enq_count - base), 32'd0);
      checkOutput("lower_occ", 32'(occupancy), 32'd1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("lower_drained", 32'(occupancy), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      checkOutput("lower_resume_enq", 32'(enq), 32'd1);
      checkOutput("lower_resume_lt", data_lt_o, 32'h4928304F);

      // Fresh start, then reset while enq is high with 2 buffered, occ 2.
      rst = 1'b1;
      #1;
      sb.delete();
      @(posedge clk);
      #1;
      rst        = 1'b0;
      array_size = 8'd2;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hA0000000 + 32'(i), 32'(i), 1'b0);
      end
      applyStimulus(1'b1, 32'hA0000004, 32'd4, 1'b1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      checkOutput("mid_enq_high", 32'(enq), 32'd1);
      checkOutput("mid_occ", 32'(occupancy), 32'd2);
      checkOutput("mid_fifo_count", 32'(dut.fifo_count), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_enq", 32'(enq), 32'd0);
      checkOutput("mid_rst_occ", 32'(occupancy), 32'd0);
      checkOutput("mid_rst_empty", 32'(q_empty), 32'd1);
      sb.delete();
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      rst  = 1'b0;
      base = enq_count;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
      end
      checkOutput("post_rst_no_enq", 32'(enq_count - base), 32'd0);
      checkOutput("post_rst_occ", 32'(occupancy), 32'd0);
      checkOutput("post_rst_fifo", 32'(dut.fifo_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
